// File: rtl/alu_matrix_loader.sv
// Serial matrix loader for the 5x5 determinant ALU: assembles an identity-padded operand and returns the result.
// Optional idle timeout in LOAD is compiled in with `define LOADER_TIMEOUT_EN.
module alu_matrix_loader #(
  parameter int SETTLE  = 1,
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [2:0]   cfg_size,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [199:0] A_flat,
  input  logic [199:0] alu_C_flat,
  input  logic         alu_overflow,
  input  logic         alu_done,
  output logic [7:0]   res_data,
  output logic         res_ovf,
  output logic         res_valid,
  input  logic         res_ready,
  output logic         busy,
  output logic         err
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_EXEC, S_WAIT, S_RESULT} state_t;

  state_t         state_q;
  logic [2:0]     n_q;
  logic [2:0]     row_q;
  logic [2:0]     col_q;
  logic [3:0]     cnt_q;
  logic [199:0]   a_q;
  logic [7:0]     res_data_q;
  logic           res_ovf_q;
  logic           err_q;
  logic [199:0]   ident;
  logic [4:0]     wr_idx;
  logic [7:0]     wr_bit;
  logic           size_ok;
  logic           unused_c_bits;

`ifdef LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]  idle_q;
`else
  localparam int unused_timeout = TIMEOUT;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 25; gi++) begin : g_ident
      assign ident[gi*8 +: 8] = ((gi / 5) == (gi % 5)) ? 8'h01 : 8'h00;
    end
  endgenerate

  assign wr_idx        = 5'(row_q) * 5'd5 + 5'(col_q);
  assign wr_bit        = {wr_idx, 3'b000};
  assign size_ok       = (cfg_size >= 3'd2) && (cfg_size <= 3'd5);
  assign unused_c_bits = ^alu_C_flat[199:8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      row_q      <= '0;
      col_q      <= '0;
      cnt_q      <= '0;
      a_q        <= '0;
      res_data_q <= '0;
      res_ovf_q  <= 1'b0;
      err_q      <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
      idle_q     <= '0;
`endif
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (size_ok) begin
              n_q     <= cfg_size;
              a_q     <= ident;
              row_q   <= '0;
              col_q   <= '0;
              cnt_q   <= '0;
`ifdef LOADER_TIMEOUT_EN
              idle_q  <= '0;
`endif
              state_q <= S_LOAD;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            a_q[wr_bit +: 8] <= in_data;
`ifdef LOADER_TIMEOUT_EN
            idle_q <= '0;
`endif
            if (col_q == n_q - 3'd1) begin
              col_q <= '0;
              if (row_q == n_q - 3'd1) begin
                row_q   <= '0;
                cnt_q   <= '0;
                state_q <= S_EXEC;
              end else begin
                row_q <= row_q + 3'd1;
              end
            end else begin
              col_q <= col_q + 3'd1;
            end
          end
`ifdef LOADER_TIMEOUT_EN
          // Abandon a stalled load: operand goes back to identity, no result is produced.
          else if (idle_q == TW'(TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            a_q     <= ident;
            row_q   <= '0;
            col_q   <= '0;
            idle_q  <= '0;
            state_q <= S_IDLE;
          end else begin
            idle_q <= idle_q + 1'b1;
          end
`endif
        end
        S_EXEC: begin
          if (cnt_q == 4'(SETTLE - 1)) begin
            cnt_q   <= '0;
            state_q <= S_WAIT;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        S_WAIT: begin
          if (alu_done) begin
            res_data_q <= alu_C_flat[7:0];
            res_ovf_q  <= alu_overflow;
            state_q    <= S_RESULT;
          end
        end
        S_RESULT: begin
          if (res_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_LOAD);
  assign res_valid = (state_q == S_RESULT);
  assign busy      = (state_q != S_IDLE);
  assign A_flat    = a_q;
  assign res_data  = res_data_q;
  assign res_ovf   = res_ovf_q;
  assign err       = err_q;

endmodule
